// File: rtl/sampled_history_monitor.sv
// sampled_history_monitor
// Reference model of the sampled-value functions ($past, $rose, $fell,
// $stable, $changed) for a watched bus. Keeps a DEPTH-deep history of
// enabled samples, publishes registered edge/stability flags and runs an
// optional toggle checker with a saturating error counter.
module sampled_history_monitor #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 16,
    localparam int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] sig_i,
    input  logic             chk_en_i,
    input  logic [SEL_W-1:0] past_sel_i,
    output logic [WIDTH-1:0] past_o,
    output logic             past_valid_o,
    output logic             rose_o,
    output logic             fell_o,
    output logic             stable_o,
    output logic             changed_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WARMUP = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    localparam int                FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WIDTH-1:0]  hist [DEPTH];
    logic [FILL_W-1:0] fill_q, fill_d;
    state_t            state_q, state_d;
    logic              rose_q, fell_q, stable_q, changed_q, err_q;
    logic [CNT_W-1:0]  err_cnt_q;

    // Comparison terms between the incoming sample and the newest history entry
    logic have_prev;
    logic differs;
    logic toggle_bad;

    assign have_prev  = (fill_q != '0);
    assign differs    = (sig_i != hist[0]);
    assign toggle_bad = (sig_i != ~hist[0]);

    // Next fill count and next FSM state; clear wins over enable
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        fill_d  = fill_q;
        state_d = state_q;
        if (clear_i) begin
            fill_d  = '0;
            state_d = ST_EMPTY;
        end else if (en_i) begin
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            case (state_q)
                ST_EMPTY:  state_d = (fill_d == FILL_MAX) ? ST_FULL : ST_WARMUP;
                ST_WARMUP: if (fill_d == FILL_MAX) state_d = ST_FULL;
                ST_FULL:   state_d = ST_FULL;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    // Fill count and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            fill_q  <= '0;
            state_q <= ST_EMPTY;
        end else begin
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    // History shift register: newest sample in hist[0]
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the history array is small and is fully reset so taps never read X.
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else if (en_i) begin
            hist[0] <= sig_i;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
        end
    end

    // Registered edge/stability flags and toggle-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rose_q    <= 1'b0;
            fell_q    <= 1'b0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (clear_i) begin
            rose_q    <= 1'b0;
            fell_q    <= 1'b0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (en_i) begin
            rose_q    <= have_prev & ~hist[0][0] &  sig_i[0];
            fell_q    <= have_prev &  hist[0][0] & ~sig_i[0];
            changed_q <= have_prev &  differs;
            stable_q  <= have_prev & ~differs;
            err_q     <= have_prev & chk_en_i & toggle_bad;
        end else begin
            // stable_q deliberately holds across disabled edges
            rose_q    <= 1'b0;
            fell_q    <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end
    end

    // Saturating toggle-error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clear_i) begin
            err_cnt_q <= '0;
        end else if (en_i && chk_en_i && have_prev && toggle_bad && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    // History tap read; out-of-range selects read as empty
    always_comb begin
        past_o       = '0;
        past_valid_o = 1'b0;
        if (int'(past_sel_i) < DEPTH) begin
            past_o       = hist[past_sel_i];
            past_valid_o = (int'(fill_q) > int'(past_sel_i));
        end
    end

    assign rose_o    = rose_q;
    assign fell_o    = fell_q;
    assign stable_o  = stable_q;
    assign changed_o = changed_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sampled_history_monitor.sv
// Testbench for sampled_history_monitor: directed scenarios plus a randomized
// run, all checked against a queue-based model of the sampled-value rules.
module tb_sampled_history_monitor;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;
    localparam int SEL_W = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, clear, en, chk_en;
    logic [WIDTH-1:0] sig;
    logic [SEL_W-1:0] past_sel;

    logic [WIDTH-1:0] d_past;
    logic             d_valid, d_rose, d_fell, d_stable, d_changed, d_err;
    logic [CNT_W-1:0] d_cnt;
    logic [1:0]       d_state;

    logic [WIDTH-1:0] s_past;
    logic             s_valid, s_rose, s_fell, s_stable, s_changed, s_err;
    logic [SAT_W-1:0] s_cnt;
    logic [1:0]       s_state;

    sampled_history_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .en_i(en), .sig_i(sig),
        .chk_en_i(chk_en), .past_sel_i(past_sel), .past_o(d_past),
        .past_valid_o(d_valid), .rose_o(d_rose), .fell_o(d_fell),
        .stable_o(d_stable), .changed_o(d_changed), .err_o(d_err),
        .err_cnt_o(d_cnt), .state_o(d_state)
    );

    sampled_history_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .en_i(en), .sig_i(sig),
        .chk_en_i(chk_en), .past_sel_i(past_sel), .past_o(s_past),
        .past_valid_o(s_valid), .rose_o(s_rose), .fell_o(s_fell),
        .stable_o(s_stable), .changed_o(s_changed), .err_o(s_err),
        .err_cnt_o(s_cnt), .state_o(s_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of enabled samples, newest at index 0
    logic [WIDTH-1:0] m_q [$];
    logic             m_rose, m_fell, m_stable, m_changed, m_err;
    int               m_cnt, m_cnt_sat, m_state;

    logic [WIDTH-1:0] exp_taps [4] = '{8'h55, 8'h44, 8'h33, 8'h22};

    function automatic void model_reset();
        m_q.delete();
        m_rose = 0; m_fell = 0; m_stable = 0; m_changed = 0; m_err = 0;
        m_cnt = 0; m_cnt_sat = 0; m_state = 0;
    endfunction

    function automatic void model_edge();
        logic [WIDTH-1:0] prev;
        if (clear) begin
            model_reset();
        end else if (en) begin
            if (m_q.size() == 0) begin
                m_rose = 0; m_fell = 0; m_stable = 0; m_changed = 0; m_err = 0;
            end else begin
                prev      = m_q[0];
                m_changed = (sig != prev);
                m_stable  = !m_changed;
                m_rose    = !prev[0] && sig[0];
                m_fell    = prev[0] && !sig[0];
                m_err     = chk_en && (sig != ~prev);
            end
            if (m_err) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (m_cnt_sat < (1 << SAT_W) - 1) m_cnt_sat++;
            end
            m_q.push_front(sig);
            if (m_q.size() > DEPTH) void'(m_q.pop_back());
            m_state = (m_q.size() == DEPTH) ? 2 : 1;
        end else begin
            m_rose = 0; m_fell = 0; m_changed = 0; m_err = 0;
        end
    endfunction

    function automatic logic [WIDTH-1:0] exp_past(int sel);
        return (sel < m_q.size()) ? m_q[sel] : '0;
    endfunction

    // One clock edge: update the model with the pre-edge inputs, then sample #1 after
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; en = 1'b0; chk_en = 1'b0; sig = '0; past_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", d_state); end
        checks++; if (d_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", d_cnt); end
        checks++; if (d_valid !== 1'b0 || d_past !== '0) begin errors++; $display("FAIL reset_past valid=%b past=%h exp 0/00", d_valid, d_past); end
        checks++; if ({d_rose, d_fell, d_stable, d_changed, d_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {d_rose, d_fell, d_stable, d_changed, d_err}); end
    endtask

    task automatic test_alternate();
        logic exp_r, exp_f;
        logic [1:0] exp_s;
        do_reset();
        en = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sig = (i % 2) ? 8'hFF : 8'h00;
            tick();
            exp_s = (i < 3) ? 2'd1 : 2'd2;
            exp_r = (i >= 1) && (sig == 8'hFF);
            exp_f = (i >= 1) && (sig == 8'h00);
            checks++; if (d_state !== exp_s) begin errors++; $display("FAIL alt_state edge=%0d got=%0d exp=%0d", i + 1, d_state, exp_s); end
            checks++; if (d_err !== 1'b0 || d_cnt !== '0) begin errors++; $display("FAIL alt_err edge=%0d err=%b cnt=%0d exp 0/0", i + 1, d_err, d_cnt); end
            checks++; if (d_rose !== exp_r || d_fell !== exp_f) begin errors++; $display("FAIL alt_edges edge=%0d rose=%b fell=%b exp %b/%b", i + 1, d_rose, d_fell, exp_r, exp_f); end
        end
    endtask

    task automatic test_past_taps();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sig = 8'h11 * WIDTH'(i + 1);
            tick();
        end
        en = 1'b0; sig = 8'hEE;
        tick();
        for (int s = 0; s < DEPTH; s++) begin
            past_sel = SEL_W'(s);
            #1;
            checks++; if (d_past !== exp_taps[s] || d_valid !== 1'b1) begin errors++; $display("FAIL taps sel=%0d past=%h valid=%b exp %h/1", s, d_past, d_valid, exp_taps[s]); end
        end
    endtask

    task automatic test_partial_fill();
        logic [WIDTH-1:0] first;
        do_reset();
        en = 1'b1;
        first = WIDTH'($urandom);
        sig = first; tick();
        sig = WIDTH'($urandom); tick();
        en = 1'b0;
        past_sel = SEL_W'(2); #1;
        checks++; if (d_valid !== 1'b0 || d_past !== '0) begin errors++; $display("FAIL partial_sel2 valid=%b past=%h exp 0/00", d_valid, d_past); end
        past_sel = SEL_W'(1); #1;
        checks++; if (d_valid !== 1'b1 || d_past !== first) begin errors++; $display("FAIL partial_sel1 valid=%b past=%h exp 1/%h", d_valid, d_past, first); end
        past_sel = '0;
    endtask

    task automatic test_stable_hold();
        do_reset();
        en = 1'b1; chk_en = 1'b1; sig = 8'hA5;
        tick();
        checks++; if (d_stable !== 1'b0 || d_err !== 1'b0) begin errors++; $display("FAIL hold_e1 stable=%b err=%b exp 0/0", d_stable, d_err); end
        tick();
        checks++; if (d_stable !== 1'b1 || d_changed !== 1'b0 || d_err !== 1'b1 || d_cnt !== 16'd1) begin errors++; $display("FAIL hold_e2 st=%b ch=%b err=%b cnt=%0d exp 1/0/1/1", d_stable, d_changed, d_err, d_cnt); end
        tick();
        checks++; if (d_stable !== 1'b1 || d_err !== 1'b1 || d_cnt !== 16'd2) begin errors++; $display("FAIL hold_e3 st=%b err=%b cnt=%0d exp 1/1/2", d_stable, d_err, d_cnt); end
        en = 1'b0; sig = 8'h00;
        tick();
        checks++; if (d_stable !== 1'b1 || d_err !== 1'b0 || d_cnt !== 16'd2) begin errors++; $display("FAIL hold_dis st=%b err=%b cnt=%0d exp 1/0/2", d_stable, d_err, d_cnt); end
    endtask

    task automatic test_disable();
        logic [WIDTH-1:0] snap [DEPTH];
        logic [WIDTH-1:0] nxt;
        do_reset();
        en = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sig = WIDTH'($urandom); tick();
            snap[i] = sig;
        end
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sig = WIDTH'($urandom); tick();
            checks++; if (d_state !== 2'd2) begin errors++; $display("FAIL dis_state cyc=%0d got=%0d exp=2", c, d_state); end
            checks++; if ({d_rose, d_fell, d_changed, d_err} !== 4'b0) begin errors++; $display("FAIL dis_flags cyc=%0d got=%b exp=0000", c, {d_rose, d_fell, d_changed, d_err}); end
            for (int s = 0; s < DEPTH; s++) begin
                past_sel = SEL_W'(s); #1;
                checks++; if (d_past !== snap[DEPTH - 1 - s]) begin errors++; $display("FAIL dis_hist cyc=%0d sel=%0d got=%h exp=%h", c, s, d_past, snap[DEPTH - 1 - s]); end
            end
        end
        past_sel = '0;
        en = 1'b1;
        nxt = ($urandom % 2) ? snap[DEPTH - 1] : WIDTH'($urandom);
        sig = nxt; tick();
        checks++; if (d_changed !== (nxt != snap[DEPTH - 1]) || d_stable !== (nxt == snap[DEPTH - 1])) begin errors++; $display("FAIL dis_resume ch=%b st=%b vs last=%h new=%h", d_changed, d_stable, snap[DEPTH - 1], nxt); end
        checks++; if (d_rose !== (!snap[DEPTH - 1][0] && nxt[0])) begin errors++; $display("FAIL dis_resume_rose got=%b last=%h new=%h", d_rose, snap[DEPTH - 1], nxt); end
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b1; chk_en = 1'b1; sig = 8'h3C;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (s_cnt !== SAT_W'((k - 1 > 3) ? 3 : k - 1)) begin errors++; $display("FAIL sat_cnt edge=%0d got=%0d exp=%0d", k, s_cnt, (k - 1 > 3) ? 3 : k - 1); end
        end
        checks++; if (d_cnt !== 16'd6) begin errors++; $display("FAIL wide_cnt got=%0d exp=6", d_cnt); end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; en = 1'b1; sig = 8'h5A;
        tick();
        clear = 1'b0; past_sel = '0; #1;
        checks++; if (d_state !== 2'd0 || d_cnt !== '0 || s_cnt !== '0) begin errors++; $display("FAIL clr_state st=%0d cnt=%0d sat=%0d exp 0/0/0", d_state, d_cnt, s_cnt); end
        checks++; if (d_valid !== 1'b0 || d_past !== '0) begin errors++; $display("FAIL clr_past valid=%b past=%h exp 0/00", d_valid, d_past); end
        checks++; if ({d_rose, d_fell, d_stable, d_changed, d_err} !== 5'b0) begin errors++; $display("FAIL clr_flags got=%b exp=00000", {d_rose, d_fell, d_stable, d_changed, d_err}); end
        sig = 8'hA5; tick();
        checks++; if (d_state !== 2'd1 || d_err !== 1'b0 || d_changed !== 1'b0) begin errors++; $display("FAIL clr_after st=%0d err=%b ch=%b exp 1/0/0", d_state, d_err, d_changed); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sig = WIDTH'($urandom); tick();
        end
        checks++; if (d_state !== 2'd2) begin errors++; $display("FAIL ar_pre state=%0d exp=2", d_state); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (d_state !== 2'd0 || d_cnt !== '0 || s_cnt !== '0) begin errors++; $display("FAIL ar_regs st=%0d cnt=%0d sat=%0d exp 0/0/0", d_state, d_cnt, s_cnt); end
        checks++; if (d_valid !== 1'b0 || d_past !== '0) begin errors++; $display("FAIL ar_past valid=%b past=%h exp 0/00", d_valid, d_past); end
        checks++; if ({d_rose, d_fell, d_stable, d_changed, d_err} !== 5'b0) begin errors++; $display("FAIL ar_flags got=%b exp=00000", {d_rose, d_fell, d_stable, d_changed, d_err}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sig = 8'hC3; tick();
        checks++; if (d_state !== 2'd1 || d_err !== 1'b0 || d_stable !== 1'b0) begin errors++; $display("FAIL ar_first st=%0d err=%b st=%b exp 1/0/0", d_state, d_err, d_stable); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] last;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            last     = (m_q.size() != 0) ? m_q[0] : '0;
            en       = ($urandom % 4) != 0;
            clear    = ($urandom % 40) == 0;
            chk_en   = $urandom % 2;
            sig      = ($urandom % 2) ? ~last : (($urandom % 3 == 0) ? last : WIDTH'($urandom));
            past_sel = SEL_W'($urandom);
            tick();
            checks++; if (d_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, d_state, m_state); end
            checks++; if ({d_rose, d_fell, d_stable, d_changed, d_err} !== {m_rose, m_fell, m_stable, m_changed, m_err}) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c, {d_rose, d_fell, d_stable, d_changed, d_err}, {m_rose, m_fell, m_stable, m_changed, m_err}); end
            checks++; if (d_cnt !== CNT_W'(m_cnt) || s_cnt !== SAT_W'(m_cnt_sat)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, d_cnt, s_cnt, m_cnt, m_cnt_sat); end
            checks++; if (d_past !== exp_past(int'(past_sel)) || d_valid !== (int'(past_sel) < m_q.size())) begin errors++; $display("FAIL rnd_past cyc=%0d sel=%0d got=%h/%b exp=%h/%b", c, past_sel, d_past, d_valid, exp_past(int'(past_sel)), int'(past_sel) < m_q.size()); end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_past_taps();
        test_partial_fill();
        test_stable_hold();
        test_disable();
        test_saturation();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
